// File: rtl/aes_pkg.sv
// Shared AES types, constants and round-function helpers for the encipher datapath.
package aes_pkg;

   localparam logic       AES_128_BIT_KEY = 1'b0;
   localparam logic       AES_256_BIT_KEY = 1'b1;
   localparam logic [3:0] AES128_ROUNDS   = 4'ha;
   localparam logic [3:0] AES256_ROUNDS   = 4'he;

   typedef enum logic [1:0] {
      CTRL_IDLE = 2'd0,
      CTRL_INIT = 2'd1,
      CTRL_SBOX = 2'd2,
      CTRL_MAIN = 2'd3
   } ctrl_state_e;

   typedef enum logic [2:0] {
      UPD_NONE  = 3'd0,
      UPD_INIT  = 3'd1,
      UPD_SBOX  = 3'd2,
      UPD_MAIN  = 3'd3,
      UPD_FINAL = 3'd4
   } upd_e;

   function automatic logic [7:0] gm2(input logic [7:0] b);
      gm2 = {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] b);
      gm3 = gm2(b) ^ b;
   endfunction

   // One FIPS-197 column through the [2 3 1 1] circulant matrix.
   function automatic logic [31:0] mixw(input logic [31:0] w);
      logic [7:0] b0, b1, b2, b3;
      b0 = w[31:24];
      b1 = w[23:16];
      b2 = w[15:8];
      b3 = w[7:0];
      mixw = {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
              b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
              b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
              gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
   endfunction

   function automatic logic [127:0] mixcolumns(input logic [127:0] data);
      mixcolumns = {mixw(data[127:96]), mixw(data[95:64]),
                    mixw(data[63:32]),  mixw(data[31:0])};
   endfunction

   // Row i (byte i of each column word) rotates left by i columns.
   function automatic logic [127:0] shiftrows(input logic [127:0] data);
      logic [31:0] w0, w1, w2, w3;
      w0 = data[127:96];
      w1 = data[95:64];
      w2 = data[63:32];
      w3 = data[31:0];
      shiftrows = {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                   w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                   w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                   w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
   endfunction

   function automatic logic [127:0] addroundkey(input logic [127:0] data,
                                                input logic [127:0] rkey);
      addroundkey = data ^ rkey;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box on a 32-bit word: four independent byte lookups, purely combinational.
module aes_sbox (
   input  logic [31:0] sboxw_i,
   output logic [31:0] new_sboxw_o
);

   // Entry 0x00 sits in the top byte, entry 0xff in the bottom byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sub_byte(input logic [7:0] x);
      sub_byte = SBOX_TABLE[{~x, 3'b000} +: 8];
   endfunction

   // Substitute all four bytes of the selected word in parallel.
   always_comb begin
      new_sboxw_o = {sub_byte(sboxw_i[31:24]), sub_byte(sboxw_i[23:16]),
                     sub_byte(sboxw_i[15:8]),  sub_byte(sboxw_i[7:0])};
   end

endmodule

// File: rtl/aes_encipher_core.sv
// Iterative AES-128/256 encipher datapath with word-serial SubBytes through one shared S-box.
//
// state | meaning
// IDLE  | waiting for next; ready=1, new_block holds last result
// INIT  | initial AddRoundKey with round key 0
// SBOX  | SubBytes on word sword_ctr, four cycles per round
// MAIN  | ShiftRows/MixColumns/AddRoundKey, or final round without MixColumns
module aes_encipher_core
   import aes_pkg::*;
(
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         next_i,
   input  logic         keylen_i,
   output logic [3:0]   round_o,
   input  logic [127:0] round_key_i,
   input  logic [127:0] block_i,
   output logic [127:0] new_block_o,
   output logic         ready_o
);

   ctrl_state_e      state_q;
   logic             ready_q;
   logic [3:0]       round_ctr_q;
   logic [1:0]       sword_ctr_q;
   logic             keylen_q;
   logic [0:3][31:0] w_q;

   logic [0:3][31:0] w_d;
   logic [3:0]       w_we;
   logic [3:0]       num_rounds;
   upd_e             upd;
   logic [31:0]      sbox_in;
   logic [31:0]      sbox_out;

   aes_sbox u_sbox (
      .sboxw_i     (sbox_in),
      .new_sboxw_o (sbox_out)
   );

   assign round_o     = round_ctr_q;
   assign new_block_o = w_q;
   assign ready_o     = ready_q;

   // Decode which datapath update the current state performs.
   always_comb begin
      num_rounds = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
      upd        = UPD_NONE;
      case (state_q)
         CTRL_INIT: upd = UPD_INIT;
         CTRL_SBOX: upd = UPD_SBOX;
         CTRL_MAIN: upd = (round_ctr_q < num_rounds) ? UPD_MAIN : UPD_FINAL;
         default:   upd = UPD_NONE;
      endcase
   end

   // Next value and per-word write enables for the state registers.
   always_comb begin
      w_d     = w_q;
      w_we    = 4'h0;
      sbox_in = w_q[sword_ctr_q];
      case (upd)
         UPD_INIT: begin
            w_d  = addroundkey(block_i, round_key_i);
            w_we = 4'hf;
         end
         UPD_SBOX: begin
            w_d[sword_ctr_q]  = sbox_out;
            w_we[sword_ctr_q] = 1'b1;
         end
         UPD_MAIN: begin
            w_d  = addroundkey(mixcolumns(shiftrows(w_q)), round_key_i);
            w_we = 4'hf;
         end
         UPD_FINAL: begin
            w_d  = addroundkey(shiftrows(w_q), round_key_i);
            w_we = 4'hf;
         end
         default: begin
            w_d  = w_q;
            w_we = 4'h0;
         end
      endcase
   end

   // State word registers; reset clears any partial result.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         w_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_we[i]) w_q[i] <= w_d[i];
         end
      end
   end

   // Control FSM with registered ready and round/word counters.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= CTRL_IDLE;
         ready_q     <= 1'b1;
         round_ctr_q <= 4'd0;
         sword_ctr_q <= 2'd0;
         keylen_q    <= 1'b0;
      end else begin
         case (state_q)
            CTRL_IDLE: begin
               if (next_i) begin
                  round_ctr_q <= 4'd0;
                  keylen_q    <= keylen_i;
                  ready_q     <= 1'b0;
                  state_q     <= CTRL_INIT;
               end
            end
            CTRL_INIT: begin
               sword_ctr_q <= 2'd0;
               state_q     <= CTRL_SBOX;
            end
            CTRL_SBOX: begin
               sword_ctr_q <= sword_ctr_q + 2'd1;
               if (sword_ctr_q == 2'd3) begin
                  round_ctr_q <= round_ctr_q + 4'd1;
                  state_q     <= CTRL_MAIN;
               end
            end
            CTRL_MAIN: begin
               sword_ctr_q <= 2'd0;
               if (round_ctr_q < num_rounds) begin
                  state_q <= CTRL_SBOX;
               end else begin
                  ready_q <= 1'b1;
                  state_q <= CTRL_IDLE;
               end
            end
            default: state_q <= CTRL_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encipher_core.sv
// Directed bench for aes_encipher_core using FIPS-197 vectors and a behavioural key memory.
module tb_aes_encipher_core;

   logic         clk;
   logic         reset;
   logic         next;
   logic         keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   logic [127:0] rk_mem [0:15];

   int n_vec = 0;
   int n_err = 0;

   localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;

   localparam logic [2047:0] TB_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16};

   aes_encipher_core dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .next_i      (next),
      .keylen_i    (keylen),
      .round_o     (round),
      .round_key_i (round_key),
      .block_i     (block),
      .new_block_o (new_block),
      .ready_o     (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb round_key = rk_mem[round];

   task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      sub_word = {TB_SBOX[{~x[31:24], 3'b000} +: 8], TB_SBOX[{~x[23:16], 3'b000} +: 8],
                  TB_SBOX[{~x[15:8],  3'b000} +: 8], TB_SBOX[{~x[7:0],   3'b000} +: 8]};
   endfunction

   // FIPS-197 key expansion into the key memory; a 128-bit key occupies key[255:128].
   task automatic expand_key(input logic [255:0] key, input logic kl);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      int nk;
      int nr;
      nk = kl ? 8 : 4;
      nr = kl ? 14 : 10;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      rc = 8'h01;
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         if (r <= nr) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else         rk_mem[r] = '0;
      end
   endtask

   // Start one block, follow it to completion and check latency, result and optional extras.
   task automatic run_block(input string tag, input logic kl, input logic [127:0] pt,
                            input logic [127:0] exp_ct, input int exp_lat,
                            input bit inj_next, input bit tog_kl, input bit chk_trace,
                            input bit chk_hold, input logic [127:0] hold_val);
      int n;
      int trace_err;
      @(negedge clk);
      block  = pt;
      keylen = kl;
      next   = 1'b1;
      @(posedge clk);
      #1;
      next = 1'b0;
      n    = 1;
      check_vec({tag, "_busy"}, {127'd0, ready}, 128'd0);
      if (chk_hold) check_vec({tag, "_hold"}, new_block, hold_val);
      trace_err = (round !== 4'd0) ? 1 : 0;
      while (!ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         next = inj_next && (n == 5 || n == 30 || n == 51);
         if (tog_kl && n == 10) keylen = ~kl;
         if (!ready && round !== 4'((n-1)/5)) trace_err++;
      end
      next = 1'b0;
      check_vec({tag, "_lat"}, 128'(n), 128'(exp_lat));
      check_vec({tag, "_ct"}, new_block, exp_ct);
      if (chk_trace) begin
         check_vec({tag, "_trace"}, 128'(trace_err), 128'd0);
         check_vec({tag, "_last_round"}, {124'd0, round}, kl ? 128'd14 : 128'd10);
      end
      if (inj_next) begin
         @(posedge clk);
         #1;
         check_vec({tag, "_stay_idle"}, {127'd0, ready}, 128'd1);
         check_vec({tag, "_stay_ct"}, new_block, exp_ct);
      end
   endtask

   initial begin
      int n;
      reset  = 1'b1;
      next   = 1'b0;
      keylen = 1'b0;
      block  = '0;
      for (int r = 0; r < 16; r++) rk_mem[r] = '0;
      repeat (3) @(posedge clk);
      #1;
      check_vec("rst_ready", {127'd0, ready}, 128'd1);
      check_vec("rst_round", {124'd0, round}, 128'd0);
      check_vec("rst_block", new_block, 128'd0);
      @(negedge clk);
      reset = 1'b0;

      expand_key({KEY_C1, 128'h0}, 1'b0);
      run_block("c1", 1'b0, PT_C, CT_C1, 52, 1'b0, 1'b0, 1'b1, 1'b0, '0);

      expand_key(KEY_C3, 1'b1);
      run_block("c3", 1'b1, PT_C, CT_C3, 72, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      run_block("c3_kltog", 1'b1, PT_C, CT_C3, 72, 1'b0, 1'b1, 1'b0, 1'b0, '0);

      expand_key({KEY_B, 128'h0}, 1'b0);
      run_block("fips_b", 1'b0, PT_B, CT_B, 52, 1'b0, 1'b0, 1'b1, 1'b0, '0);

      expand_key({KEY_C1, 128'h0}, 1'b0);
      run_block("c1_inj", 1'b0, PT_C, CT_C1, 52, 1'b1, 1'b0, 1'b0, 1'b0, '0);

      expand_key(KEY_C3, 1'b1);
      @(negedge clk);
      block  = PT_C;
      keylen = 1'b1;
      next   = 1'b1;
      @(posedge clk);
      #1;
      next = 1'b0;
      n    = 1;
      while (n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_vec("abort_busy", {127'd0, ready}, 128'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_vec("abort_ready", {127'd0, ready}, 128'd1);
      check_vec("abort_round", {124'd0, round}, 128'd0);
      check_vec("abort_block", new_block, 128'd0);
      expand_key({KEY_C1, 128'h0}, 1'b0);
      run_block("after_abort", 1'b0, PT_C, CT_C1, 52, 1'b0, 1'b0, 1'b0, 1'b0, '0);

      expand_key({KEY_B, 128'h0}, 1'b0);
      run_block("b2b_1", 1'b0, PT_B, CT_B, 52, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      expand_key({KEY_C1, 128'h0}, 1'b0);
      run_block("b2b_2", 1'b0, PT_C, CT_C1, 52, 1'b0, 1'b0, 1'b0, 1'b1, CT_B);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
